// File: rtl/cordic_cossin_arbiter.sv
// Round-robin arbiter sharing one serial cordicCosSin core between NREQ requesters.
// Define CORDIC_ARB_FIXED_PRIORITY_EN for fixed priority (lowest index wins) instead of round-robin.
module cordic_cossin_arbiter #(
    parameter int NREQ      = 4,
    parameter int PHI_WIDTH = 16,
    localparam int ID_WIDTH = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*PHI_WIDTH-1:0] req_phi,
    output logic [NREQ-1:0]           req_ready,
    output logic                      core_st,
    output logic [PHI_WIDTH-1:0]      core_phi,
    input  logic                      core_rdy,
    input  logic [PHI_WIDTH-1:0]      core_cos,
    input  logic [PHI_WIDTH-1:0]      core_sin,
    output logic                      res_valid,
    output logic [ID_WIDTH-1:0]       res_id,
    output logic [PHI_WIDTH-1:0]      res_cos,
    output logic [PHI_WIDTH-1:0]      res_sin,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LOW, WAIT_RDY} state_t;

    state_t                      state, state_nxt;
    logic [PHI_WIDTH-1:0]        phi_arr [NREQ];
    logic [PHI_WIDTH-1:0]        phi_reg;
    logic [ID_WIDTH-1:0]         id_reg;
    logic                        grant_any;
    logic [ID_WIDTH-1:0]         grant_idx;
    logic [ID_WIDTH-1:0]         cand;
    logic                        accept;
    logic                        capture;
    logic signed [PHI_WIDTH-1:0] cos_in, sin_in;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign phi_arr[gi] = req_phi[gi*PHI_WIDTH +: PHI_WIDTH];
    end

`ifdef CORDIC_ARB_FIXED_PRIORITY_EN
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ID_WIDTH'(k);
            if (req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end
`else
    logic [ID_WIDTH-1:0] ptr;
    logic [ID_WIDTH:0]   rr_sum;

    // Scan ptr+1, ptr+2, ... modulo NREQ; the last winner ends up lowest priority.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        rr_sum    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_sum = {1'b0, ptr} + (ID_WIDTH+1)'(k);
            if (rr_sum >= (ID_WIDTH+1)'(NREQ))
                rr_sum = rr_sum - (ID_WIDTH+1)'(NREQ);
            cand = rr_sum[ID_WIDTH-1:0];
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end
`endif

    // Grants wait for core_rdy so a stale completion after reset is never forwarded.
    assign accept    = reset && (state == IDLE) && core_rdy && grant_any;
    assign capture   = (state == WAIT_RDY) && core_rdy;
    assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;
    assign core_st   = (state == ISSUE);
    assign core_phi  = (state == IDLE) ? '0 : phi_reg;
    assign busy      = (state != IDLE);
    assign cos_in    = core_cos;
    assign sin_in    = core_sin;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept)    state_nxt = ISSUE;
            ISSUE:                   state_nxt = WAIT_LOW;
            WAIT_LOW: if (!core_rdy) state_nxt = WAIT_RDY;
            WAIT_RDY: if (core_rdy)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phi_reg   <= '0;
            id_reg    <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_cos   <= '0;
            res_sin   <= '0;
`ifndef CORDIC_ARB_FIXED_PRIORITY_EN
            ptr       <= ID_WIDTH'(NREQ - 1);
`endif
        end else begin
            res_valid <= capture;
            if (accept) begin
                phi_reg <= phi_arr[grant_idx];
                id_reg  <= grant_idx;
`ifndef CORDIC_ARB_FIXED_PRIORITY_EN
                ptr     <= grant_idx;
`endif
            end
            if (capture) begin
                res_cos <= cos_in;
                res_sin <= sin_in;
                res_id  <= id_reg;
            end
        end
    end

endmodule

// File: tb/tb_cordic_cossin_arbiter.sv
// Scoreboard bench for cordic_cossin_arbiter with a behavioural serial core (16-cycle busy, cos=phi+1, sin=-phi).
module tb_cordic_cossin_arbiter;
    localparam int NREQ = 4;
    localparam int PW   = 16;
    localparam int IDW  = $clog2(NREQ);
    localparam int LAT  = 19;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*PW-1:0] req_phi;
    logic              core_st, core_rdy, res_valid, busy;
    logic [PW-1:0]     core_phi, core_cos, core_sin, res_cos, res_sin;
    logic [IDW-1:0]    res_id;

    always #5 clk = ~clk;

    cordic_cossin_arbiter #(.NREQ(NREQ), .PHI_WIDTH(PW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_phi(req_phi),
        .req_ready(req_ready), .core_st(core_st), .core_phi(core_phi),
        .core_rdy(core_rdy), .core_cos(core_cos), .core_sin(core_sin),
        .res_valid(res_valid), .res_id(res_id), .res_cos(res_cos),
        .res_sin(res_sin), .busy(busy)
    );

    // Requesters
    logic [NREQ-1:0] pend_valid = '0;
    logic [NREQ-1:0] hold = '0;
    logic [PW-1:0]   pend_phi [NREQ];
    assign req_valid = pend_valid;
    always_comb begin
        req_phi = '0;
        for (int i = 0; i < NREQ; i++) req_phi[i*PW +: PW] = pend_phi[i];
    end

    // Behavioural core
    logic       crdy_int = 1'b1;
    int         ccnt = 0;
    logic [PW-1:0] cphi = '0;
    int         cycle = 0;
    int         hold_until = 0;
    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (core_st) begin
            crdy_int <= 1'b0;
            ccnt     <= 16;
            cphi     <= core_phi;
        end else if (ccnt > 1) begin
            ccnt <= ccnt - 1;
        end else if (ccnt == 1) begin
            crdy_int <= 1'b1;
            ccnt     <= 0;
        end
    end
    assign core_rdy = crdy_int && (cycle >= hold_until);
    assign core_cos = cphi + 16'd1;
    assign core_sin = 16'd0 - cphi;

    typedef struct {
        int            id;
        logic [PW-1:0] phi;
        logic [PW-1:0] cos;
        logic [PW-1:0] sin;
        int            t;
    } exp_t;
    exp_t sbq[$];
    int   glog[$];

    int nchk = 0, nerr = 0;
    int ngrant = 0, nres = 0, nst = 0;
    int last_g = NREQ - 1;
    int last_gc = 0;
    bit inflight = 0;
    int cyc_in = 0;
    logic [PW-1:0] cur_phi = '0;
    int clr_idx = 0;
    event clr_ev;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int last);
`ifdef CORDIC_ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
        return -1;
    endfunction

    // Monitor / scoreboard
    initial begin
        exp_t e;
        int g;
        logic [NREQ-1:0] expg;
        logic [PW-1:0] ph;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk({req_ready, core_st, core_phi, res_valid, res_id, res_cos, res_sin, busy} == '0,
                    "reset_outputs", {req_ready, core_st, core_phi, res_valid, res_id, res_cos, res_sin, busy}, 0);
                if (inflight && sbq.size() > 0) begin
                    e = sbq[0];
                    pend_phi[e.id]   = e.phi;
                    pend_valid[e.id] = 1'b1;
                end
                sbq.delete();
                inflight = 0;
                last_g   = NREQ - 1;
            end else begin
                if (res_valid) begin
                    if (sbq.size() == 0) begin
                        chk(0, "res_unexpected", res_id, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk(res_id == IDW'(e.id), "res_id", res_id, e.id);
                        chk(res_cos == e.cos, "res_cos", res_cos, e.cos);
                        chk(res_sin == e.sin, "res_sin", res_sin, e.sin);
                        chk(cycle - e.t == LAT, "latency", cycle - e.t, LAT);
                        nres++;
                    end
                    inflight = 0;
                end
                if (!inflight) begin
                    chk(core_phi == '0 && !busy && !core_st, "idle_outputs", {core_st, busy, core_phi}, 0);
                    expg = '0;
                    g = -1;
                    if (core_rdy && req_valid != '0) begin
                        g = pick(req_valid, last_g);
                        expg = NREQ'(1) << g;
                    end
                    chk(req_ready == expg, "grant", req_ready, expg);
                    if (g >= 0) begin
                        ph = req_phi[g*PW +: PW];
                        sbq.push_back('{g, ph, ph + 16'd1, 16'd0 - ph, cycle});
                        glog.push_back(g);
                        inflight = 1;
                        cyc_in   = 0;
                        cur_phi  = ph;
                        last_g   = g;
                        last_gc  = cycle;
                        ngrant++;
                        clr_idx  = g;
                        -> clr_ev;
                    end
                end else begin
                    cyc_in++;
                    chk(req_ready == '0 && busy, "busy_no_grant", {busy, req_ready}, 1 << NREQ);
                    chk(core_st == (cyc_in == 1), "core_st", core_st, cyc_in == 1);
                    chk(core_phi == cur_phi, "core_phi", core_phi, cur_phi);
                    if (core_st) nst++;
                end
            end
        end
    end

    // A granted requester drops its request, or re-requests with a new phase when held
    initial begin
        forever begin
            @(clr_ev);
            @(posedge clk);
            #1;
            if (hold[clr_idx]) pend_phi[clr_idx] = PW'($urandom);
            else               pend_valid[clr_idx] = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(1);
        reset = 1'b0;
        cyc(3);
        reset = 1'b1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((pend_valid != '0 || inflight || sbq.size() != 0) && t < 3000) begin
            cyc(1);
            t++;
        end
        chk(t < 3000, "drain_timeout", t, 3000);
        cyc(2);
    endtask

    task automatic wait_grants(input int target);
        int t = 0;
        while (ngrant < target && t < 2000) begin
            cyc(1);
            t++;
        end
        chk(t < 2000, "grant_timeout", ngrant, target);
    endtask

    task automatic check_alt(input string nm, input int a, input int b, input int n);
        chk(glog.size() >= n, {nm, "_count"}, glog.size(), n);
        for (int k = 0; k < n && k < glog.size(); k++)
            chk(glog[k] == ((k % 2 == 0) ? a : b), nm, glog[k], (k % 2 == 0) ? a : b);
    endtask

    initial begin
        int st0, r0, g0;
        for (int i = 0; i < NREQ; i++) pend_phi[i] = '0;
        cyc(3);
        reset = 1'b1;
        cyc(2);

        // Single request
        glog.delete(); r0 = nres; st0 = nst;
        pend_phi[0] = 16'h1000; pend_valid[0] = 1'b1;
        wait_idle();
        chk(glog.size() == 1 && glog[0] == 0, "single_grant", glog.size(), 1);
        chk(nres - r0 == 1 && nst - st0 == 1, "single_counts", {nres - r0, nst - st0}, {32'd1, 32'd1});

        // Four simultaneous requests
        do_reset();
        glog.delete(); st0 = nst;
        for (int i = 0; i < NREQ; i++) begin
            pend_phi[i] = PW'(10 * (i + 1));
            pend_valid[i] = 1'b1;
        end
        wait_idle();
        check_alt("all4_order_a", 0, 1, 1);
        for (int k = 0; k < 4; k++) chk(glog.size() == 4 && glog[k] == k, "all4_order", glog[k], k);
        chk(nst - st0 == 4, "all4_st_pulses", nst - st0, 4);

        // Requesters 0 and 2 held
        glog.delete(); g0 = ngrant;
        hold[0] = 1'b1; hold[2] = 1'b1;
        pend_phi[0] = PW'($urandom); pend_phi[2] = PW'($urandom);
        pend_valid[0] = 1'b1; pend_valid[2] = 1'b1;
        wait_grants(g0 + 8);
        hold = '0; pend_valid = '0;
        wait_idle();
`ifdef CORDIC_ARB_FIXED_PRIORITY_EN
        check_alt("hold02_seq", 0, 0, 8);
`else
        check_alt("hold02_seq", 0, 2, 8);
`endif
        for (int k = 0; k < glog.size(); k++)
            chk(glog[k] != 1 && glog[k] != 3, "hold02_no13", glog[k], 0);

        // Core not ready for 30 cycles after reset release
        cyc(1);
        reset = 1'b0;
        cyc(2);
        hold_until = cycle + 30;
        pend_phi[1] = PW'($urandom); pend_valid[1] = 1'b1;
        reset = 1'b1;
        glog.delete();
        wait_idle();
        chk(glog.size() == 1 && last_gc >= hold_until, "rdy_hold_grant", last_gc, hold_until);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend_valid[i] && $urandom_range(0, 7) == 0) begin
                    pend_phi[i] = PW'($urandom);
                    pend_valid[i] = 1'b1;
                end else if (pend_valid[i] && $urandom_range(0, 63) == 0) begin
                    pend_valid[i] = 1'b0;
                end
            end
            cyc(1);
        end
        wait_idle();

        // Reset while waiting for the core
        g0 = ngrant;
        pend_phi[2] = PW'($urandom); pend_valid[2] = 1'b1;
        wait_grants(g0 + 1);
        cyc(8);
        r0 = nres;
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk({req_ready, core_st, core_phi, res_valid, res_id, res_cos, res_sin, busy} == '0,
            "async_reset_outputs", {req_ready, core_st, core_phi, res_valid, res_id, res_cos, res_sin, busy}, 0);
        cyc(2);
        reset = 1'b1;
        wait_idle();
        chk(nres - r0 == 1, "reset_single_delivery", nres - r0, 1);

        // Requesters 1 and 3 held
        do_reset();
        glog.delete(); g0 = ngrant;
        hold[1] = 1'b1; hold[3] = 1'b1;
        pend_phi[1] = PW'($urandom); pend_phi[3] = PW'($urandom);
        pend_valid[1] = 1'b1; pend_valid[3] = 1'b1;
        wait_grants(g0 + 6);
        hold = '0; pend_valid = '0;
        wait_idle();
`ifdef CORDIC_ARB_FIXED_PRIORITY_EN
        check_alt("hold13_seq", 1, 1, 6);
`else
        check_alt("hold13_seq", 1, 3, 6);
`endif
        chk(nst == ngrant, "st_vs_grants", nst, ngrant);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
